data_mem_responder: RTL
=======================

# data_mem_responder

Data-memory slave for the RV32I core's load/store port. It accepts one request at a time over a valid/ready handshake and inserts a programmable number of wait states. Stores write the low byte, half or word of the write data into the addressed byte lanes. Loads return the addressed byte or half right-justified and zero-filled; the core applies sign or zero extension. Misaligned, out-of-range and illegal-size requests are rejected with an error response and no side effects.

## Interface
- ADDR_WIDTH, 10, word-address width; the array is 2**ADDR_WIDTH x 32 bits, a 4 KiB byte space by default.
- WAIT_CYCLES, 1, wait states between accept and access; legal range 0-15.

- clk  in  1  clock, rising edge.
- reset  in  1  reset, asynchronous, active-high; clock clk.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_size  in  3  RV32I funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  32  load data, right-justified, upper bits zero.
- rsp_err  out  1  request rejected; qualified by rsp_valid.

## Operation
- **FSM states:** IDLE, BUSY, RESP.
  - IDLE: req_ready = 1.
  - On req_valid & req_ready, register we/addr/size/wdata, load cnt = WAIT_CYCLES, go to BUSY.
  - BUSY: if cnt != 0, decrement cnt. If cnt == 0, perform the access and go to RESP.
  - RESP: rsp_valid = 1 for exactly one cycle, then IDLE.
- **Error checks (err = 1 if any holds):**
  - req_addr[31:ADDR_WIDTH+2] != 0.
  - Size is h/hu and addr[0] = 1.
  - Size is w and addr[1:0] != 0.
  - req_size is 011, 110 or 111.
  - Store with size 100 or 101.
- **On error:** no array write, rsp_rdata = 0, rsp_err = 1.
- **Word index:** addr[ADDR_WIDTH+1:2].
- **Store lane selection:**
  - Byte: lane addr[1:0] receives wdata[7:0].
  - Half: lanes {addr[1],1'b1}:{addr[1],1'b0} receive wdata[15:0].
  - Word: all four lanes receive wdata.
  - Unselected lanes are unchanged.
- **Load data:** lane-select from the stored word.
  - b/bu: {24'b0, byte at addr[1:0]}.
  - h/hu: {16'b0, half at addr[1]}.
  - w: the full word.
- **Store response:** rsp_rdata = 0, rsp_err = 0.
- **Reset values:**
  - State IDLE; req_ready = 1 once reset deasserts.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - cnt and captured request regs = 0.
  - Array contents are not reset.
- **Reset mid-operation:** the pending request is discarded. If reset asserts before the access edge, no write occurs and no response is issued.
- **Request-input sampling:** req inputs are ignored outside IDLE. A req_valid held high during BUSY/RESP is not accepted until the next IDLE cycle.

## Timing
- Accept edge E0.
  - Access (array read/write) occurs at edge E0+WAIT_CYCLES+1.
  - rsp_valid is high in the cycle after that edge.
  - The state returns to IDLE at E0+WAIT_CYCLES+2.
- Throughput: one request per WAIT_CYCLES+3 cycles when req_valid is held high.
- rsp_rdata and rsp_err are registered. They hold their values after rsp_valid falls until the next response.
- Read-after-write to the same address in consecutive transactions returns the new data.
- Single clock domain; no combinational path from req_* to rsp_*. req_ready is a function of state only.

## Test plan
- **Word store/load (WAIT_CYCLES=1):**
  - Stimulus: sw addr 0x10 data 0xDEADBEEF, then lw addr 0x10.
  - Required: rsp_valid 2 edges after each accept; second rsp_rdata = 0xDEADBEEF, rsp_err = 0.
- **Byte store into lane 3:**
  - Stimulus: after the word store above, sb addr 0x13 data 0x000000A5, then lw 0x10 and lbu 0x13.
  - Required: lw returns 0xA5ADBEEF; lbu returns 0x000000A5.
- **Half load:**
  - Stimulus: lh addr 0x12 on the 0xA5ADBEEF word.
  - Required: rsp_rdata = 0x0000A5AD.
- **Misaligned and illegal requests:**
  - Stimulus: sw at 0x22, lh at 0x11, store with size 100.
  - Required: each gives rsp_err = 1 and rsp_rdata = 0; a later lw 0x20 shows the word unchanged.
- **Out-of-range load:**
  - Stimulus: lw at 0x1000 with ADDR_WIDTH=10.
  - Required: rsp_err = 1.
- **Reset mid-operation (WAIT_CYCLES=3):**
  - Stimulus: accept sw 0x40 data 0x12345678; pulse reset during the second BUSY cycle; then lw 0x40.
  - Required: no rsp_valid for the aborted store; req_ready = 1 after reset; lw returns the prior contents of 0x40 (bench pre-writes 0x0).
- **Zero wait states and held req_valid:**
  - Stimulus: WAIT_CYCLES=0, req_valid held high for two requests.
  - Required: rsp_valid one edge after each accept; second accept occurs 3 cycles after the first.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Data-memory slave for the RV32I load/store port. Takes one request at a
//   time over a valid/ready handshake, waits WAIT_CYCLES cycles, performs the
//   array access, then emits a one-cycle response strobe. Misaligned,
//   out-of-range and illegal-size requests return rsp_err with no side effects.
//
// Parameters
//   ADDR_WIDTH   word-address width; array is 2**ADDR_WIDTH x 32 bits
//   WAIT_CYCLES  wait states between accept and access (0-15)
//
// Ports
//   clk, reset                 clock (rising edge), async active-high reset
//   req_valid / req_ready      request handshake; ready only in IDLE
//   req_we, req_addr           1 = store / byte address
//   req_size                   RV32I funct3 (b, h, w, bu, hu)
//   req_wdata                  right-justified store data
//   rsp_valid                  one-cycle response strobe
//   rsp_rdata, rsp_err         registered load data / error, held until next response
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t state, state_nxt;

    logic [3:0]  cnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [2:0]  size_q;
    logic [31:0] wdata_q;

    logic [31:0] mem [2**ADDR_WIDTH];

    logic                  accept;
    logic                  access;
    logic                  err;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [31:0]           rd_word;
    logic [31:0]           load_data;
    logic [3:0]            byte_en;
    logic [31:0]           wr_lanes;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign access    = (state == BUSY) && (cnt == 4'd0);
    assign word_idx  = addr_q[ADDR_WIDTH+1:2];
    assign rd_word   = mem[word_idx];

    // Next-state logic.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request legality, evaluated on the captured request at access time.
    always_comb begin
        err = ((addr_q >> (ADDR_WIDTH + 2)) != 32'd0);
        case (size_q)
            3'b000, 3'b100: ;
            3'b001, 3'b101: if (addr_q[0]) err = 1'b1;
            3'b010:         if (addr_q[1:0] != 2'b00) err = 1'b1;
            default:        err = 1'b1;
        endcase
        // Unsigned sizes only make sense for loads.
        if (we_q && size_q[2]) err = 1'b1;
    end

    // Lane selection for loads (right-justified, zero-filled) and stores.
    always_comb begin
        load_data = 32'd0;
        byte_en   = 4'b0000;
        wr_lanes  = wdata_q;
        case (size_q[1:0])
            2'b00: begin
                load_data = {24'd0, rd_word[8*addr_q[1:0] +: 8]};
                byte_en   = 4'b0001 << addr_q[1:0];
                wr_lanes  = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                load_data = {16'd0, rd_word[16*addr_q[1] +: 16]};
                byte_en   = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_lanes  = {2{wdata_q[15:0]}};
            end
            default: begin
                load_data = rd_word;
                byte_en   = 4'b1111;
                wr_lanes  = wdata_q;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            size_q    <= 3'd0;
            wdata_q   <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            rsp_valid <= access;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                size_q  <= req_size;
                wdata_q <= req_wdata;
                cnt     <= 4'(WAIT_CYCLES);
            end else if ((state == BUSY) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                rsp_err   <= err;
                rsp_rdata <= (err || we_q) ? 32'd0 : load_data;
            end
        end
    end

    // NOTE: the array has no reset; a reset forces state to IDLE, which alone blocks any write.
    always_ff @(posedge clk) begin
        if (access && we_q && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
            end
        end
    end

endmodule
